// File: rtl/intra_pkg.sv
// Shared types and constants for the intra edge path.
package intra_pkg;

    typedef logic [29:0] pix_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REF  = 3'd1,
        EDGE = 3'd2,
        PAD  = 3'd3,
        OUT  = 3'd4
    } edge_state_t;

    // Component positions inside a packed {V,U,Y} pixel word.
    localparam int PIX_Y_LSB = 0;
    localparam int PIX_Y_MSB = 9;
    localparam int PIX_U_LSB = 10;
    localparam int PIX_U_MSB = 19;
    localparam int PIX_V_LSB = 20;
    localparam int PIX_V_MSB = 29;

    // Mid-grey fill pixel (Y=U=V=512) used when no neighbour is available.
    localparam pix_t PIX_BASE_10B = 30'h2008_0200;

endpackage

// File: rtl/intra_edge_builder.sv
// Collects one intra prediction edge (corner pixel plus up to NUMPX edge
// samples) from a valid/ready pixel stream, pads unavailable samples, and
// hands the finished edge to the upsampler through a valid/ready handshake.
module intra_edge_builder
    import intra_pkg::*;
#(
    parameter int   NUMPX = 8,
    parameter pix_t BASE  = PIX_BASE_10B
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [9:0]            i_num_px,
    input  logic                  i_have_ref,
    input  logic                  i_have_edge,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [29:0]           i_in_pixel,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [29:0]           o_reference_pixel,
    output logic [30*NUMPX-1:0]   o_edge_array,
    output logic [9:0]            o_out_num_px
);

    localparam int CW = $clog2(NUMPX + 1);
    localparam int IW = (NUMPX > 1) ? $clog2(NUMPX) : 1;

    edge_state_t   r_state;
    edge_state_t   w_next;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_have_ref;
    logic          r_have_edge;
    logic [CW-1:0] r_n;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_n;
    logic          w_accept;
    pix_t          r_ref;
    pix_t          r_last;
    pix_t          r_edge [NUMPX];

    // in_ready is only ever high in REF/EDGE, so this alone qualifies a transfer.
    assign w_accept = i_in_valid && r_in_ready;

    // Clamp the requested sample count into 1..NUMPX.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
        w_n = i_num_px[CW-1:0];
        if (i_num_px == '0) begin
            w_n = CW'(1);
        end else if (i_num_px > 10'(NUMPX)) begin
            w_n = CW'(NUMPX);
        end
    end

    // Next-state decode of the edge collection FSM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (i_have_ref)       w_next = REF;
                    else if (i_have_edge) w_next = EDGE;
                    else                  w_next = PAD;
                end
            end
            REF: begin
                if (w_accept) w_next = r_have_edge ? EDGE : PAD;
            end
            EDGE: begin
                if (w_accept && (r_cnt == r_n - CW'(1))) w_next = PAD;
            end
            PAD:     w_next = OUT;
            OUT: begin
                if (i_out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State, handshake flags and edge storage; the pad step fills the unused tail.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the edge array is reset on purpose: an aborted edge must leave no stale pixels visible.
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_have_ref  <= 1'b0;
            r_have_edge <= 1'b0;
            r_n         <= '0;
            r_cnt       <= '0;
            r_ref       <= '0;
            r_last      <= '0;
            for (int i = 0; i < NUMPX; i++) begin
                r_edge[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            r_state     <= w_next;
            r_in_ready  <= (w_next == REF) || (w_next == EDGE);
            r_out_valid <= (w_next == OUT);
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_n         <= w_n;
                        r_have_ref  <= i_have_ref;
                        r_have_edge <= i_have_edge;
                        r_cnt       <= '0;
                    end
                end
                REF: begin
                    if (w_accept) r_ref <= i_in_pixel;
                end
                EDGE: begin
                    if (w_accept) begin
                        r_edge[r_cnt[IW-1:0]] <= i_in_pixel;
                        r_last                <= i_in_pixel;
                        r_cnt                 <= r_cnt + CW'(1);
                    end
                end
                PAD: begin
                    for (int i = 0; i < NUMPX; i++) begin
                        if (CW'(i) >= r_cnt) begin
                            r_edge[i] <= r_have_edge ? r_last : BASE;
                        end
                    end
                    if (!r_have_ref) begin
                        r_ref <= r_have_edge ? r_edge[0] : BASE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Flatten the edge storage onto the output bus, slot 0 in the low bits.
    always_comb begin
        o_edge_array = '0;
        for (int i = 0; i < NUMPX; i++) begin
            o_edge_array[i*30 +: 30] = r_edge[i];
        end
    end

    assign o_in_ready        = r_in_ready;
    assign o_out_valid       = r_out_valid;
    assign o_reference_pixel = r_ref;
    assign o_out_num_px      = 10'(r_n);

endmodule

// File: tb/tb_intra_edge_builder.sv
// Directed bench for intra_edge_builder: full edges, padding, no-stream fill,
// count clamping, stalls, output back-pressure and mid-edge reset.
module tb_intra_edge_builder;

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic [9:0]   i_num_px;
    logic         i_have_ref;
    logic         i_have_edge;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [29:0]  i_in_pixel;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [29:0]  o_reference_pixel;
    logic [239:0] o_edge_array;
    logic [9:0]   o_out_num_px;

    localparam logic [29:0] BASE_PX = 30'h2008_0200;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;
    logic [29:0] exp_e [8];

    intra_edge_builder dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_start           (i_start),
        .i_num_px          (i_num_px),
        .i_have_ref        (i_have_ref),
        .i_have_edge       (i_have_edge),
        .i_in_valid        (i_in_valid),
        .o_in_ready        (o_in_ready),
        .i_in_pixel        (i_in_pixel),
        .o_out_valid       (o_out_valid),
        .i_out_ready       (i_out_ready),
        .o_reference_pixel (o_reference_pixel),
        .o_edge_array      (o_edge_array),
        .o_out_num_px      (o_out_num_px)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] px(input int t, input int k);
        return {10'(t), 10'(k * 3 + 1), 10'(t * 32 + k)};
    endfunction

    function automatic logic [239:0] exp_flat();
        logic [239:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[i*30 +: 30] = exp_e[i];
        return f;
    endfunction

    task automatic check(input string tag, input logic [239:0] obs, input logic [239:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_start(input int n, input logic hr, input logic he);
        t0          = cyc;
        i_num_px    = 10'(n);
        i_have_ref  = hr;
        i_have_edge = he;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic send(input logic [29:0] p);
        int k;
        k          = 0;
        i_in_valid = 1'b1;
        i_in_pixel = p;
        while (!o_in_ready && k < 40) begin
            tick();
            k++;
        end
        if (!o_in_ready) check("send_timeout", {239'd0, o_in_ready}, 240'd1);
        tick();
        i_in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int k;
        k = 0;
        while (!o_out_valid && k < 40) begin
            tick();
            k++;
        end
        if (!o_out_valid) check("out_timeout", {239'd0, o_out_valid}, 240'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_num_px    = '0;
        i_have_ref  = 1'b0;
        i_have_edge = 1'b0;
        i_in_valid  = 1'b0;
        i_in_pixel  = '0;
        i_out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_in_ready", 240'(o_in_ready), 240'd0);
        check("rst_out_valid", 240'(o_out_valid), 240'd0);
        check("rst_ref", 240'(o_reference_pixel), 240'd0);
        check("rst_array", o_edge_array, 240'd0);
        check("rst_num", 240'(o_out_num_px), 240'd0);
        rst_n = 1'b1;
        tick();

        // 1: corner + 8 edge pixels, back-to-back, out_ready high
        do_start(8, 1'b1, 1'b1);
        send(px(1, 99));
        for (int k = 0; k < 8; k++) send(px(1, k));
        wait_out();
        check("t1_latency", 240'(cyc - t0), 240'd11);
        for (int k = 0; k < 8; k++) exp_e[k] = px(1, k);
        check("t1_array", o_edge_array, exp_flat());
        check("t1_ref", 240'(o_reference_pixel), 240'(px(1, 99)));
        check("t1_num", 240'(o_out_num_px), 240'd8);
        tick();
        check("t1_valid_drop", 240'(o_out_valid), 240'd0);

        // 2: corner + 4 edge pixels, tail padded with the last pixel
        do_start(4, 1'b1, 1'b1);
        send(px(2, 99));
        for (int k = 0; k < 4; k++) send(px(2, k));
        check("t2_ready_low", 240'(o_in_ready), 240'd0);
        wait_out();
        check("t2_latency", 240'(cyc - t0), 240'd7);
        for (int k = 0; k < 8; k++) exp_e[k] = px(2, (k < 4) ? k : 3);
        check("t2_array", o_edge_array, exp_flat());
        check("t2_ref", 240'(o_reference_pixel), 240'(px(2, 99)));
        check("t2_num", 240'(o_out_num_px), 240'd4);
        tick();

        // 3: no corner; reference comes from slot 0; an extra pixel is refused
        do_start(8, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) send(px(3, k));
        i_in_valid = 1'b1;
        i_in_pixel = px(3, 50);
        check("t3_extra_refused", 240'(o_in_ready), 240'd0);
        tick();
        i_in_valid = 1'b0;
        check("t3_valid", 240'(o_out_valid), 240'd1);
        check("t3_latency", 240'(cyc - t0), 240'd10);
        for (int k = 0; k < 8; k++) exp_e[k] = px(3, k);
        check("t3_array", o_edge_array, exp_flat());
        check("t3_ref", 240'(o_reference_pixel), 240'(px(3, 0)));
        tick();

        // 4: nothing available, everything is BASE
        do_start(8, 1'b0, 1'b0);
        check("t4_ready_c1", 240'(o_in_ready), 240'd0);
        tick();
        check("t4_ready_c2", 240'(o_in_ready), 240'd0);
        check("t4_valid_c2", 240'(o_out_valid), 240'd1);
        for (int k = 0; k < 8; k++) exp_e[k] = BASE_PX;
        check("t4_array", o_edge_array, exp_flat());
        check("t4_ref", 240'(o_reference_pixel), 240'(BASE_PX));
        check("t4_num", 240'(o_out_num_px), 240'd8);
        tick();

        // 5a: num_px=0 clamps to one sample
        do_start(0, 1'b0, 1'b1);
        send(px(4, 7));
        wait_out();
        check("t5a_latency", 240'(cyc - t0), 240'd3);
        check("t5a_num", 240'(o_out_num_px), 240'd1);
        for (int k = 0; k < 8; k++) exp_e[k] = px(4, 7);
        check("t5a_array", o_edge_array, exp_flat());
        check("t5a_ref", 240'(o_reference_pixel), 240'(px(4, 7)));
        tick();

        // 5b: num_px=20 clamps to 8, 3-cycle stall, 5-cycle back-pressure
        i_out_ready = 1'b0;
        do_start(20, 1'b1, 1'b1);
        send(px(5, 99));
        send(px(5, 0));
        send(px(5, 1));
        tick();
        tick();
        tick();
        for (int k = 2; k < 8; k++) send(px(5, k));
        wait_out();
        check("t5b_latency", 240'(cyc - t0), 240'd14);
        check("t5b_num", 240'(o_out_num_px), 240'd8);
        for (int k = 0; k < 8; k++) exp_e[k] = px(5, k);
        i_in_valid = 1'b1;
        i_in_pixel = px(5, 60);
        i_start    = 1'b1;
        for (int h = 0; h < 5; h++) tick();
        i_in_valid = 1'b0;
        i_start    = 1'b0;
        check("t5b_hold_valid", 240'(o_out_valid), 240'd1);
        check("t5b_hold_array", o_edge_array, exp_flat());
        check("t5b_hold_ref", 240'(o_reference_pixel), 240'(px(5, 99)));
        check("t5b_hold_num", 240'(o_out_num_px), 240'd8);
        i_out_ready = 1'b1;
        tick();
        check("t5b_released", 240'(o_out_valid), 240'd0);

        // 6: reset after 3 accepts, then a fresh short edge
        do_start(8, 1'b1, 1'b1);
        send(px(6, 99));
        send(px(6, 0));
        send(px(6, 1));
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", 240'(o_out_valid), 240'd0);
        check("t6_rst_ready", 240'(o_in_ready), 240'd0);
        check("t6_rst_array", o_edge_array, 240'd0);
        check("t6_rst_ref", 240'(o_reference_pixel), 240'd0);
        rst_n = 1'b1;
        tick();
        do_start(2, 1'b0, 1'b1);
        send(px(7, 0));
        send(px(7, 1));
        wait_out();
        for (int k = 0; k < 8; k++) exp_e[k] = px(7, (k < 2) ? k : 1);
        check("t6_array", o_edge_array, exp_flat());
        check("t6_ref", 240'(o_reference_pixel), 240'(px(7, 0)));
        check("t6_num", 240'(o_out_num_px), 240'd2);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
